icache_refill_ctrl: RTL and testbench

//   Controller for the byte-addressable instruction code store. Holds a direct-mapped tag/valid array, detects misses.
//   On a miss, stalls the fetch stage and sequences a line refill: one word-request per beat to the memory side,

---
 rtl/icache_pkg.sv | 39 +++
 rtl/icache_tag_array.sv | 41 ++++
 rtl/icache_refill_ctrl.sv | 149 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the instruction cache refill controller.
package icache_pkg;

    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned NUM_LINES_DEF  = 64;
    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned MAX_ADDR_W     = 64;

    localparam int unsigned OFFSET_W = $clog2(LINE_WORDS_DEF * 4);
    localparam int unsigned INDEX_W  = $clog2(NUM_LINES_DEF);
    localparam int unsigned TAG_W    = ADDR_W_DEF - OFFSET_W - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_e;

    // Helpers take widths as arguments so any legal geometry can share them.
    function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned off_w,
                                                         input int unsigned idx_w);
        logic [MAX_ADDR_W-1:0] mask;
        mask = (MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1);
        return (addr >> off_w) & mask;
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned off_w,
                                                       input int unsigned idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_line_base(input logic [MAX_ADDR_W-1:0] addr,
                                                             input int unsigned off_w);
        return (addr >> off_w) << off_w;
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Direct-mapped tag/valid store: combinational read, single write port, one-cycle invalidate of all lines.
module icache_tag_array #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_W     = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clear_all
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache controller: hit/miss lookup, fetch stall, line refill sequencing, flush and misalignment flag.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic              fetch_stall,
    output logic              misaligned,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              refill_we,
    output logic [ADDR_W-1:0] refill_address,
    output logic [31:0]       refill_data,
    input  logic              flush,
    output logic [15:0]       refill_count
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic                flush_pend_q, flush_pend_d;
    logic [15:0]         refill_count_q, refill_count_d;
    logic                misaligned_q, misaligned_d;

    logic [IDX_W-1:0]    fetch_idx, line_idx;
    logic [TG_W-1:0]     fetch_tag, line_tag;
    logic                rd_valid;
    logic [TG_W-1:0]     rd_tag;
    logic                hit_c, misalign_now_c;
    logic                tag_we, clear_all;

    assign fetch_idx      = IDX_W'(addr_index(MAX_ADDR_W'(fetch_address), OFF_W, IDX_W));
    assign fetch_tag      = TG_W'(addr_tag(MAX_ADDR_W'(fetch_address), OFF_W, IDX_W));
    assign line_idx       = IDX_W'(addr_index(MAX_ADDR_W'(line_base_q), OFF_W, IDX_W));
    assign line_tag       = TG_W'(addr_tag(MAX_ADDR_W'(line_base_q), OFF_W, IDX_W));
    assign hit_c          = rd_valid & (rd_tag == fetch_tag);
    assign misalign_now_c = (fetch_address[1:0] != 2'b00);

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (fetch_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .we        (tag_we),
        .wr_idx    (line_idx),
        .wr_tag    (line_tag),
        .clear_all (clear_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            line_base_q    <= '0;
            flush_pend_q   <= 1'b0;
            refill_count_q <= '0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            line_base_q    <= line_base_d;
            flush_pend_q   <= flush_pend_d;
            refill_count_q <= refill_count_d;
            misaligned_q   <= misaligned_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        line_base_d    = line_base_q;
        flush_pend_d   = flush_pend_q;
        refill_count_d = refill_count_q;
        misaligned_d   = misaligned_q;
        fetch_stall    = 1'b1;
        mem_req        = 1'b0;
        mem_addr       = '0;
        refill_we      = 1'b0;
        refill_address = '0;
        refill_data    = '0;
        tag_we         = 1'b0;
        clear_all      = 1'b0;

        case (state_q)
            IDLE: begin
                fetch_stall = fetch_valid & ~misalign_now_c & ~hit_c;
                if (fetch_valid) begin
                    misaligned_d = misalign_now_c;
                end
                // Flush wins over a miss; the stalled fetch simply misses again next cycle.
                if (flush || flush_pend_q) begin
                    clear_all    = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (fetch_stall) begin
                    line_base_d = ADDR_W'(addr_line_base(MAX_ADDR_W'(fetch_address), OFF_W));
                    beat_d      = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                flush_pend_d = flush_pend_q | flush;
                mem_req      = 1'b1;
                mem_addr     = line_base_q + ADDR_W'({beat_q, 2'b00});
                if (mem_ack) begin
                    refill_we      = 1'b1;
                    refill_address = mem_addr;
                    refill_data    = mem_rdata;
                    beat_d         = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                flush_pend_d = flush_pend_q | flush;
                tag_we       = 1'b1;
                if (refill_count_q != 16'hFFFF) begin
                    refill_count_d = refill_count_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign misaligned   = misaligned_q;
    assign refill_count = refill_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a refill-write scoreboard checked by an independent monitor.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_address;
    logic        fetch_stall;
    logic        misaligned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        refill_we;
    logic [31:0] refill_address;
    logic [31:0] refill_data;
    logic        flush;
    logic [15:0] refill_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  mem_req_cycles = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    icache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_address  (fetch_address),
        .fetch_stall    (fetch_stall),
        .misaligned     (misaligned),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .refill_we      (refill_we),
        .refill_address (refill_address),
        .refill_data    (refill_data),
        .flush          (flush),
        .refill_count   (refill_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = base + 32'(4 * i);
            e.data = mem_word(e.addr);
            exp_q.push_back(e);
        end
    endtask

    // Present a fetch and hold it until the stall drops; returns the number of stalled cycles.
    task automatic do_fetch(input logic [31:0] addr, output int stall_cycles);
        @(posedge clk); #1;
        fetch_valid   = 1'b1;
        fetch_address = addr;
        stall_cycles  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fetch_stall) stall_cycles++;
            else break;
        end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic wait_beat_addr(input logic [31:0] addr, output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == addr) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: every code-store write must match the next expected word; a held request must keep its address.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) mem_req_cycles++;
            if (refill_we) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%08h expected no write", refill_address);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("refill_address", refill_address, e.addr);
                    check("refill_data", refill_data, e.data);
                    check("mem_addr_on_ack", mem_addr, e.addr);
                end
            end else if (mem_req && !mem_ack && exp_q.size() != 0) begin
                check("mem_addr_hold", mem_addr, exp_q[0].addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        int  req0;
        bit  found;

        rst = 1'b1; fetch_valid = 1'b0; fetch_address = '0; mem_ack = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fetch_stall", 32'(fetch_stall), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_refill_we", 32'(refill_we), 32'd0);
        check("rst_refill_count", 32'(refill_count), 32'd0);

        // 1: cold miss with ack tied high
        push_line(32'h40, 4);
        do_fetch(32'h40, st);
        check("t1_stall_cycles", 32'(st), 32'd6);
        check("t1_writes_done", 32'(exp_q.size()), 32'd0);
        check("t1_refill_count", 32'(refill_count), 32'd1);

        // 2: hit on last word of the line
        req0 = mem_req_cycles;
        do_fetch(32'h4C, st);
        check("t2_stall_cycles", 32'(st), 32'd0);
        check("t2_mem_req_cycles", 32'(mem_req_cycles - req0), 32'd0);

        // 3: conflicting tag on index 4 evicts, then original line misses again
        push_line(32'h440, 4);
        do_fetch(32'h440, st);
        check("t3a_stall_cycles", 32'(st), 32'd6);
        push_line(32'h40, 4);
        do_fetch(32'h40, st);
        check("t3b_stall_cycles", 32'(st), 32'd6);
        check("t3_refill_count", 32'(refill_count), 32'd3);

        // 4: flush while idle, then refill with ack withheld for 3 cycles on beat 1
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        push_line(32'h40, 4);
        fork
            do_fetch(32'h40, st);
            begin
                wait_beat_addr(32'h44, found);
                check("t4_beat1_seen", 32'(found), 32'd1);
                mem_ack = 1'b0;
                repeat (3) @(posedge clk);
                #1 mem_ack = 1'b1;
            end
        join
        check("t4_stall_cycles", 32'(st), 32'd9);
        check("t4_refill_count", 32'(refill_count), 32'd4);

        // 5: flush pulse during beat 2 is deferred until after commit
        push_line(32'h440, 4);
        fork
            do_fetch(32'h440, st);
            begin
                wait_beat_addr(32'h448, found);
                check("t5_beat2_seen", 32'(found), 32'd1);
                flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
            end
        join
        check("t5_stall_cycles", 32'(st), 32'd6);
        check("t5_refill_count", 32'(refill_count), 32'd5);
        push_line(32'h440, 4);
        do_fetch(32'h440, st);
        check("t5_refetch_stall", 32'(st), 32'd6);
        push_line(32'h40, 4);
        do_fetch(32'h40, st);
        check("t5_other_stall", 32'(st), 32'd6);
        check("t5_refill_count2", 32'(refill_count), 32'd7);

        // 6: misaligned fetch, then aligned hit clears the flag
        req0 = mem_req_cycles;
        do_fetch(32'h42, st);
        @(negedge clk);
        check("t6_mis_stall", 32'(st), 32'd0);
        check("t6_mis_flag", 32'(misaligned), 32'd1);
        check("t6_mis_no_req", 32'(mem_req_cycles - req0), 32'd0);
        do_fetch(32'h40, st);
        @(negedge clk);
        check("t6_hit_stall", 32'(st), 32'd0);
        check("t6_mis_clear", 32'(misaligned), 32'd0);

        // 6: reset after two beats of a refill aborts it
        push_line(32'h80, 2);
        @(posedge clk); #1;
        fetch_valid   = 1'b1;
        fetch_address = 32'h80;
        wait_beat_addr(32'h88, found);
        check("t6_beat2_seen", 32'(found), 32'd1);
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst         = 1'b0;
        mem_ack     = 1'b1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("t6_rst_mem_req", 32'(mem_req), 32'd0);
        check("t6_rst_count", 32'(refill_count), 32'd0);
        check("t6_rst_partial", 32'(exp_q.size()), 32'd0);
        push_line(32'h40, 4);
        do_fetch(32'h40, st);
        check("t6_post_rst_stall", 32'(st), 32'd6);
        check("t6_post_rst_count", 32'(refill_count), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
